// File: rtl/morse_symbol_timer_pkg.sv
// Shared Morse timing types and default constants.
// Used by the symbol timer and the downstream lookup stage.
package morse_symbol_timer_pkg;

  localparam int DEF_TICK_DIV   = 50000;
  localparam int DEF_DASH_MIN   = 200;
  localparam int DEF_LETTER_GAP = 300;
  localparam int DEF_WORD_GAP   = 700;
  localparam int DEF_CNT_W      = 12;
  localparam int DEF_MAX_SYM    = 5;
  localparam int LEN_W          = 3;

  typedef enum logic [1:0] {
    S_IDLE,
    S_PRESS,
    S_GAP,
    S_WAIT_WORD
  } state_t;

endpackage

// File: rtl/morse_tick_gen.sv
// Timing-tick prescaler: one-cycle tick every DIV clocks.
// Ports: clk_fast, rst_n, restart (sync phase reset), tick.
module morse_tick_gen #(
  parameter int DIV = 50000
) (
  input  logic clk_fast,
  input  logic rst_n,
  input  logic restart,
  output logic tick
);

  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);
  // The restart cycle itself is phase 0 of the new interval.
  localparam logic [W-1:0] FIRST = (DIV > 1) ? W'(1) : '0;

  logic [W-1:0] cnt;

  assign tick = (cnt == LAST);

  always_ff @(posedge clk_fast or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (restart) begin
      cnt <= FIRST;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/morse_symbol_timer.sv
// Times key presses/releases into dots, dashes, letters, words.
// Ports: clk_fast, rst_n, key_db in; sym_*, letter_*, word_end out.
module morse_symbol_timer
  import morse_symbol_timer_pkg::*;
#(
  parameter int TICK_DIV   = DEF_TICK_DIV,
  parameter int DASH_MIN   = DEF_DASH_MIN,
  parameter int LETTER_GAP = DEF_LETTER_GAP,
  parameter int WORD_GAP   = DEF_WORD_GAP,
  parameter int CNT_W      = DEF_CNT_W,
  parameter int MAX_SYM    = DEF_MAX_SYM
) (
  input  logic               clk_fast,
  input  logic               rst_n,
  input  logic               key_db,
  output logic               sym_valid,
  output logic               sym_dash,
  output logic               letter_valid,
  output logic [MAX_SYM-1:0] letter_bits,
  output logic [LEN_W-1:0]   letter_len,
  output logic               letter_err,
  output logic               word_end
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t             state;
  logic               key_d;
  logic               key_edge;
  logic               key_rise;
  logic               key_fall;
  logic               tick;
  logic [CNT_W-1:0]   cnt;
  logic [MAX_SYM-1:0] bits;
  logic [LEN_W-1:0]   len;
  logic               ovf;
  logic               is_dash;
  logic               gap_done;
  logic               word_done;

  assign key_edge  = key_db ^ key_d;
  assign key_rise  = key_edge & key_db;
  assign key_fall  = key_edge & ~key_db;
  assign is_dash   = (cnt >= CNT_W'(DASH_MIN));
  assign gap_done  = (cnt >= CNT_W'(LETTER_GAP));
  assign word_done = (cnt >= CNT_W'(WORD_GAP));

  morse_tick_gen #(
    .DIV(TICK_DIV)
  ) u_tick (
    .clk_fast(clk_fast),
    .rst_n   (rst_n),
    .restart (key_edge),
    .tick    (tick)
  );

  always_ff @(posedge clk_fast or negedge rst_n) begin
    if (!rst_n) begin
      key_d <= 1'b0;
      cnt   <= '0;
    end else begin
      key_d <= key_db;
      if (key_edge) begin
        cnt <= '0;
      end else if (tick && state != S_IDLE
                   && cnt != CNT_MAX) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_fast or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      bits         <= '0;
      len          <= '0;
      ovf          <= 1'b0;
      sym_valid    <= 1'b0;
      sym_dash     <= 1'b0;
      letter_valid <= 1'b0;
      letter_bits  <= '0;
      letter_len   <= '0;
      letter_err   <= 1'b0;
      word_end     <= 1'b0;
    end else begin
      sym_valid    <= 1'b0;
      letter_valid <= 1'b0;
      word_end     <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (key_rise) state <= S_PRESS;
        end
        S_PRESS: begin
          if (key_fall) begin
            sym_valid <= 1'b1;
            sym_dash  <= is_dash;
            if (int'(len) < MAX_SYM) begin
              bits[len] <= is_dash;
              len       <= len + 1'b1;
            end else begin
              ovf <= 1'b1;
            end
            state <= S_GAP;
          end
        end
        S_GAP: begin
          // A press landing on the closing cycle starts
          // the next letter instead of being lost.
          if (gap_done) begin
            letter_valid <= 1'b1;
            letter_bits  <= bits;
            letter_len   <= len;
            letter_err   <= ovf;
            bits         <= '0;
            len          <= '0;
            ovf          <= 1'b0;
            state <= key_rise ? S_PRESS : S_WAIT_WORD;
          end else if (key_rise) begin
            state <= S_PRESS;
          end
        end
        S_WAIT_WORD: begin
          if (word_done) begin
            word_end <= 1'b1;
            state    <= key_rise ? S_PRESS : S_IDLE;
          end else if (key_rise) begin
            state <= S_PRESS;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_morse_symbol_timer.sv
// Self-checking bench for morse_symbol_timer.
// Waveform-level reference model, directed plus random runs.
module tb_morse_symbol_timer;

  localparam int D  = 4;
  localparam int DM = 3;
  localparam int LG = 5;
  localparam int WG = 10;
  localparam int CW = 4;
  localparam int MS = 5;

  logic          clk_fast = 1'b0;
  logic          rst_n    = 1'b0;
  logic          key_db   = 1'b0;
  logic          sym_valid;
  logic          sym_dash;
  logic          letter_valid;
  logic [MS-1:0] letter_bits;
  logic [2:0]    letter_len;
  logic          letter_err;
  logic          word_end;

  typedef struct packed {
    logic       sv;
    logic       sd;
    logic       lv;
    logic [4:0] lb;
    logic [2:0] ll;
    logic       le;
    logic       we;
  } obs_t;

  int   n_tests = 0;
  int   n_fail  = 0;
  bit   wq[$];
  obs_t expv[];
  bit   checking = 1'b0;
  int   ci = 0;
  int   chk_len = 0;
  int   n_sym = 0;
  int   n_let = 0;
  int   n_word = 0;
  obs_t got;
  int   idx;

  morse_symbol_timer #(
    .TICK_DIV  (D),
    .DASH_MIN  (DM),
    .LETTER_GAP(LG),
    .WORD_GAP  (WG),
    .CNT_W     (CW),
    .MAX_SYM   (MS)
  ) dut (
    .clk_fast    (clk_fast),
    .rst_n       (rst_n),
    .key_db      (key_db),
    .sym_valid   (sym_valid),
    .sym_dash    (sym_dash),
    .letter_valid(letter_valid),
    .letter_bits (letter_bits),
    .letter_len  (letter_len),
    .letter_err  (letter_err),
    .word_end    (word_end)
  );

  initial forever #5 clk_fast = ~clk_fast;

  function automatic obs_t sample();
    return {sym_valid, sym_dash, letter_valid,
            letter_bits, letter_len, letter_err, word_end};
  endfunction

  task automatic check_val(string name, int g, int w);
    n_tests++;
    if (g != w) begin
      n_fail++;
      $display("FAIL %s: got %0d want %0d", name, g, w);
    end
  endtask

  task automatic check_zero(string name);
    obs_t o;
    o = sample();
    n_tests++;
    if (o != '0) begin
      n_fail++;
      $display("FAIL %s: outputs %b want all zero", name, o);
    end
  endtask

  // Key sample t is the level seen at posedge t; outputs
  // registered at that edge are expected in expv[t].
  function automatic void build_model();
    int   n;
    int   r;
    int   nsym;
    int   nr;
    int   rel;
    bit   prev;
    bit   d;
    logic [4:0] b;
    obs_t h;
    n = wq.size();
    expv = new[n];
    for (int t = 0; t < n; t++) expv[t] = '0;
    r = 0;
    nsym = 0;
    b = '0;
    prev = 1'b0;
    for (int t = 0; t < n; t++) begin
      if (wq[t] && !prev) r = t;
      if (!wq[t] && prev) begin
        d = ((t - r) >= DM * D);
        expv[t].sv = 1'b1;
        expv[t].sd = d;
        if (nsym < MS) b[nsym] = d;
        nsym++;
        nr = t;
        while (nr < n && !wq[nr]) nr++;
        rel = (nr == n) ? 1000000 : nr - t;
        if (rel >= LG * D) begin
          if (t + LG * D < n) begin
            expv[t+LG*D].lv = 1'b1;
            expv[t+LG*D].lb = b;
            expv[t+LG*D].ll = 3'((nsym > MS) ? MS : nsym);
            expv[t+LG*D].le = (nsym > MS);
          end
          b = '0;
          nsym = 0;
          if (rel >= WG * D && t + WG * D < n)
            expv[t+WG*D].we = 1'b1;
        end
      end
      prev = wq[t];
    end
    h = '0;
    for (int t = 0; t < n; t++) begin
      if (expv[t].sv) h.sd = expv[t].sd;
      else expv[t].sd = h.sd;
      if (expv[t].lv) begin
        h.lb = expv[t].lb;
        h.ll = expv[t].ll;
        h.le = expv[t].le;
      end else begin
        expv[t].lb = h.lb;
        expv[t].ll = h.ll;
        expv[t].le = h.le;
      end
    end
  endfunction

  always @(posedge clk_fast) begin
    if (checking && ci < chk_len) begin
      idx = ci;
      #1;
      got = sample();
      n_sym  += int'(got.sv);
      n_let  += int'(got.lv);
      n_word += int'(got.we);
      n_tests++;
      if (got != expv[idx]) begin
        n_fail++;
        $display("FAIL cyc %0d: got sv%b sd%b lv%b lb%b ll%0d le%b we%b want sv%b sd%b lv%b lb%b ll%0d le%b we%b",
                 idx, got.sv, got.sd, got.lv, got.lb, got.ll,
                 got.le, got.we, expv[idx].sv, expv[idx].sd,
                 expv[idx].lv, expv[idx].lb, expv[idx].ll,
                 expv[idx].le, expv[idx].we);
      end
      ci = idx + 1;
    end
  end

  task automatic add(bit lvl, int cyc);
    for (int i = 0; i < cyc; i++) wq.push_back(lvl);
  endtask

  task automatic run_wave();
    build_model();
    n_sym = 0;
    n_let = 0;
    n_word = 0;
    for (int t = 0; t < wq.size(); t++) begin
      @(negedge clk_fast);
      if (t == 0) begin
        ci = 0;
        chk_len = wq.size();
        checking = 1'b1;
      end
      key_db = wq[t];
    end
    @(negedge clk_fast);
    checking = 1'b0;
  endtask

  task automatic do_reset(string name);
    @(negedge clk_fast);
    #2;
    rst_n = 1'b0;
    key_db = 1'b0;
    #1;
    check_zero(name);
    repeat (2) @(negedge clk_fast);
    rst_n = 1'b1;
    wq.delete();
  endtask

  int near_gap[6] = '{19, 20, 21, 39, 40, 41};
  int sel;
  bit lvl;

  initial begin
    // 1: single dot -> "E"
    do_reset("reset_1");
    add(0, 2); add(1, 8); add(0, 30);
    run_wave();
    check_val("m1_sym", int'(expv[10].sv), 1);
    check_val("m1_dash", int'(expv[10].sd), 0);
    check_val("m1_lv", int'(expv[30].lv), 1);
    check_val("m1_len", int'(expv[30].ll), 1);
    check_val("m1_bits", int'(expv[30].lb), 0);
    check_val("d1_nlet", n_let, 1);

    // 2: dash dot dot dot -> "B"
    do_reset("reset_2");
    add(1, 12);
    for (int i = 0; i < 3; i++) begin
      add(0, 8); add(1, 8);
    end
    add(0, 45);
    run_wave();
    check_val("m2_dash", int'(expv[12].sd), 1);
    check_val("m2_bits", int'(expv[80].lb), 1);
    check_val("m2_len", int'(expv[80].ll), 4);
    check_val("m2_word", int'(expv[100].we), 1);
    check_val("d2_nsym", n_sym, 4);

    // 3: dash threshold, dot just below, 4-tick gap continues
    do_reset("reset_3");
    add(1, 12); add(0, 16); add(1, 11); add(0, 25);
    run_wave();
    check_val("m3_dash", int'(expv[12].sd), 1);
    check_val("m3_dot", int'(expv[39].sv && !expv[39].sd), 1);
    check_val("m3_len", int'(expv[59].ll), 2);
    check_val("m3_bits", int'(expv[59].lb), 1);

    // 4: letter and word end exactly once
    do_reset("reset_4");
    add(0, 1); add(1, 8); add(0, 60);
    run_wave();
    check_val("m4_word", int'(expv[49].we), 1);
    check_val("d4_nlet", n_let, 1);
    check_val("d4_nword", n_word, 1);

    // 5: six symbols overflow, next letter clean
    do_reset("reset_5");
    for (int i = 0; i < 6; i++) begin
      add(1, 8); add(0, (i == 5) ? 25 : 4);
    end
    add(1, 8); add(0, 25);
    run_wave();
    check_val("m5_len", int'(expv[88].ll), 5);
    check_val("m5_err", int'(expv[88].le), 1);
    check_val("m5_err2", int'(expv[121].le), 0);
    check_val("d5_nsym", n_sym, 7);
    check_val("d5_nlet", n_let, 2);

    // 6: reset mid-press discards everything
    do_reset("reset_6a");
    add(1, 10);
    run_wave();
    do_reset("reset_6b");
    add(0, 80);
    run_wave();
    check_val("d6_pulses", n_sym + n_let + n_word, 0);

    // random runs incl. boundary gaps and saturating presses
    for (int k = 0; k < 8; k++) begin
      do_reset("reset_rnd");
      lvl = bit'($urandom_range(0, 1));
      for (int s = 0; s < 30; s++) begin
        sel = int'($urandom_range(0, 9));
        if (lvl) begin
          if (sel < 5) add(1, int'($urandom_range(1, 14)));
          else if (sel < 8) add(1, int'($urandom_range(11, 13)));
          else add(1, int'($urandom_range(40, 90)));
        end else begin
          if (sel < 4) add(0, int'($urandom_range(1, 19)));
          else if (sel < 7)
            add(0, near_gap[$urandom_range(0, 5)]);
          else add(0, int'($urandom_range(20, 60)));
        end
        lvl = !lvl;
      end
      add(0, 45);
      run_wave();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
